// File: rtl/rf_addr_encoder.sv
// rf_addr_encoder
// ---------------
// Serial encoder that turns a stream of register-file entries back into the
// compressed per-group description (kernel row r, kernel index k, group start
// pointer) plus the total entry count. It is the inverse of the
// address-to-RF expander.
//
// Optional feature macro: RF_COL_CHECK_EN
//   defined   : every accepted entry is also checked for i_col == i_w - i_s
//               (7-bit wrap); a mismatch sets o_err.
//   undefined : i_col is ignored; o_err reflects only the row-range check.
//
// Ports
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_start            begin a pass (sampled only in IDLE); latches i_h/i_w/i_s
//   i_h, i_w, i_s      window row base, column base, column offset
//   i_valid, o_ready   entry handshake (see below)
//   i_row/i_col/i_kidx entry fields (h - r, w - s, k)
//   i_last             marks the final entry of the pass
//   o_r/o_k/o_ptr      per-group kernel row, kernel index, start index
//   o_groups           number of groups recorded (0..K)
//   o_length           number of entries accepted
//   o_overflow         more than K groups were opened, or o_length wrapped
//   o_err              row out of range (or column mismatch when enabled)
//   o_finish           one-cycle pulse in the DONE state
//   o_state            FSM state (0 IDLE, 1 RECV, 2 DONE) for observation
//
// Handshake: an entry transfers on a rising edge where i_valid and o_ready are
// both high. o_ready is high for the whole RECV state and low elsewhere, so
// there is no backpressure inside a pass; i_valid outside RECV is ignored.

module rf_addr_encoder #(
  parameter int K     = 4,
  parameter int PTR_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [6:0]       i_h,
  input  logic [6:0]       i_w,
  input  logic [2:0]       i_s,
  input  logic             i_valid,
  input  logic [6:0]       i_row,
  input  logic [6:0]       i_col,
  input  logic [6:0]       i_kidx,
  input  logic             i_last,
  output logic             o_ready,
  output logic [2:0]       o_r   [0:K-1],
  output logic [4:0]       o_k   [0:K-1],
  output logic [PTR_W-1:0] o_ptr [0:K-1],
  output logic [2:0]       o_groups,
  output logic [PTR_W-1:0] o_length,
  output logic             o_overflow,
  output logic             o_err,
  output logic             o_finish,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] GRP_MAX = 3'(K);

  state_t     state;
  logic [6:0] h_q;
  logic [6:0] w_q;
  logic [2:0] s_q;
  logic [2:0] cur_r;
  logic [4:0] cur_k;
  logic       first_q;

  logic             accept;
  logic [7:0]       d;
  logic             range_err;
  logic [2:0]       ent_r;
  logic [4:0]       ent_k;
  logic [6:0]       exp_col;
  logic             col_mismatch;
  logic             col_err;
  logic             open_grp;
  logic             grp_full;
  logic             len_wrap;
  logic [PTR_W-1:0] len_nxt;
  logic [2:0]       grp_nxt;
  logic             unused_bits;

  assign o_state = state;

  always_comb begin
    accept       = 1'b0;
    d            = 8'd0;
    range_err    = 1'b0;
    ent_r        = 3'd0;
    ent_k        = 5'd0;
    exp_col      = 7'd0;
    col_mismatch = 1'b0;
    col_err      = 1'b0;
    open_grp     = 1'b0;
    grp_full     = 1'b0;
    len_wrap     = 1'b0;
    len_nxt      = '0;
    grp_nxt      = 3'd0;

    accept = (state == RECV) && i_valid;
    // 8-bit signed difference: bit 7 set means negative, bits 6:3 set means
    // larger than 7; either way the row lies outside the 8-row kernel.
    d         = {1'b0, h_q} - {1'b0, i_row};
    range_err = (d[7:3] != 5'd0);
    ent_r     = d[2:0];
    ent_k     = i_kidx[4:0];

    exp_col      = w_q - {4'd0, s_q};
    col_mismatch = (i_col != exp_col);
`ifdef RF_COL_CHECK_EN
    col_err = col_mismatch;
`else
    col_err = 1'b0;
`endif

    // A group opens on the first entry or whenever (r,k) changes relative to
    // the most recently opened group, even if that group did not fit.
    open_grp = first_q || (ent_r != cur_r) || (ent_k != cur_k);
    grp_full = (o_groups == GRP_MAX);
    len_wrap = &o_length;
    len_nxt  = o_length + 1'b1;
    grp_nxt  = (open_grp && !grp_full) ? o_groups + 3'd1 : o_groups;
  end

  // Bits that are deliberately not used for any decision in every build.
  assign unused_bits = ^{i_kidx[6:5], col_mismatch};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      h_q        <= 7'd0;
      w_q        <= 7'd0;
      s_q        <= 3'd0;
      cur_r      <= 3'd0;
      cur_k      <= 5'd0;
      first_q    <= 1'b0;
      o_ready    <= 1'b0;
      o_groups   <= 3'd0;
      o_length   <= '0;
      o_overflow <= 1'b0;
      o_err      <= 1'b0;
      o_finish   <= 1'b0;
      for (int g = 0; g < K; g++) begin
        o_r[g]   <= 3'd0;
        o_k[g]   <= 5'd0;
        o_ptr[g] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          o_finish <= 1'b0;
          if (i_start) begin
            h_q        <= i_h;
            w_q        <= i_w;
            s_q        <= i_s;
            cur_r      <= 3'd0;
            cur_k      <= 5'd0;
            first_q    <= 1'b1;
            o_groups   <= 3'd0;
            o_length   <= '0;
            o_overflow <= 1'b0;
            o_err      <= 1'b0;
            for (int g = 0; g < K; g++) begin
              o_r[g]   <= 3'd0;
              o_k[g]   <= 5'd0;
              o_ptr[g] <= '0;
            end
            o_ready <= 1'b1;
            state   <= RECV;
          end
        end

        RECV: begin
          if (accept) begin
            o_length <= len_nxt;
            first_q  <= 1'b0;
            if (len_wrap) o_overflow <= 1'b1;
            if (range_err || col_err) o_err <= 1'b1;
            if (open_grp) begin
              cur_r <= ent_r;
              cur_k <= ent_k;
              if (grp_full) begin
                o_overflow <= 1'b1;
              end else begin
                o_groups <= o_groups + 3'd1;
                for (int g = 0; g < K; g++) begin
                  if (3'(g) == o_groups) begin
                    o_r[g]   <= ent_r;
                    o_k[g]   <= ent_k;
                    o_ptr[g] <= o_length;
                  end
                end
              end
            end
            if (i_last) begin
              // Unused slots point at the end of the stream; their r/k were
              // already cleared at i_start. The condition excludes any slot
              // opened by this same entry.
              for (int g = 0; g < K; g++) begin
                if (3'(g) >= grp_nxt) o_ptr[g] <= len_nxt;
              end
              o_ready  <= 1'b0;
              o_finish <= 1'b1;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          o_finish <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          o_ready  <= 1'b0;
          o_finish <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_addr_encoder.sv
// Testbench for rf_addr_encoder: a table of directed passes with hand-computed
// results, plus hand-written sequences for reset mid-pass, ignored controls and
// length wrap-around.

module tb_rf_addr_encoder;

  localparam int K     = 4;
  localparam int PTR_W = 11;
  localparam int NV    = 7;

`ifdef RF_COL_CHECK_EN
  localparam logic COL_ERR_EXP = 1'b1;
`else
  localparam logic COL_ERR_EXP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             i_start = 1'b0;
  logic [6:0]       i_h = '0, i_w = '0;
  logic [2:0]       i_s = '0;
  logic             i_valid = 1'b0;
  logic [6:0]       i_row = '0, i_col = '0, i_kidx = '0;
  logic             i_last = 1'b0;
  logic             o_ready;
  logic [2:0]       o_r   [0:K-1];
  logic [4:0]       o_k   [0:K-1];
  logic [PTR_W-1:0] o_ptr [0:K-1];
  logic [2:0]       o_groups;
  logic [PTR_W-1:0] o_length;
  logic             o_overflow, o_err, o_finish;
  logic [1:0]       o_state;

  rf_addr_encoder #(.K(K), .PTR_W(PTR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start),
    .i_h(i_h), .i_w(i_w), .i_s(i_s),
    .i_valid(i_valid), .i_row(i_row), .i_col(i_col), .i_kidx(i_kidx),
    .i_last(i_last), .o_ready(o_ready),
    .o_r(o_r), .o_k(o_k), .o_ptr(o_ptr),
    .o_groups(o_groups), .o_length(o_length),
    .o_overflow(o_overflow), .o_err(o_err), .o_finish(o_finish),
    .o_state(o_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    int                      n;
    logic [6:0]              h, w;
    logic [2:0]              s;
    logic [5:0][6:0]         row, col, kidx;
    logic [3:0][2:0]         er;
    logic [3:0][4:0]         ek;
    logic [3:0][PTR_W-1:0]   eptr;
    logic [2:0]              egroups;
    logic [PTR_W-1:0]        elen;
    logic                    eovf, eerr;
  } vec_t;

  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_hdr(input int v, input int n, input logic [6:0] h, input logic [6:0] w,
                         input logic [2:0] s, input logic [2:0] groups,
                         input logic [PTR_W-1:0] len, input logic ovf, input logic err);
    vecs[v].n = n; vecs[v].h = h; vecs[v].w = w; vecs[v].s = s;
    vecs[v].egroups = groups; vecs[v].elen = len; vecs[v].eovf = ovf; vecs[v].eerr = err;
    vecs[v].row = '0; vecs[v].col = '0; vecs[v].kidx = '0;
  endtask

  task automatic set_ent(input int v, input int i, input logic [6:0] row,
                         input logic [6:0] col, input logic [6:0] kidx);
    vecs[v].row[i] = row; vecs[v].col[i] = col; vecs[v].kidx[i] = kidx;
  endtask

  task automatic set_grp(input int v, input int g, input logic [2:0] r,
                         input logic [4:0] k, input logic [PTR_W-1:0] ptr);
    vecs[v].er[g] = r; vecs[v].ek[g] = k; vecs[v].eptr[g] = ptr;
  endtask

  // ---------------- driver tasks ----------------
  // All driving happens 1 time unit after a rising edge; sampling likewise.
  task automatic start_pass(input logic [6:0] h, input logic [6:0] w, input logic [2:0] s);
    i_start = 1'b1; i_h = h; i_w = w; i_s = s;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send(input logic [6:0] row, input logic [6:0] col,
                      input logic [6:0] kidx, input logic last);
    i_valid = 1'b1; i_row = row; i_col = col; i_kidx = kidx; i_last = last;
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic check_results(input int v);
    for (int g = 0; g < K; g++) begin
      check($sformatf("v%0d r[%0d]", v, g),   32'(o_r[g]),   32'(vecs[v].er[g]));
      check($sformatf("v%0d k[%0d]", v, g),   32'(o_k[g]),   32'(vecs[v].ek[g]));
      check($sformatf("v%0d ptr[%0d]", v, g), 32'(o_ptr[g]), 32'(vecs[v].eptr[g]));
    end
    check($sformatf("v%0d groups", v),   32'(o_groups),   32'(vecs[v].egroups));
    check($sformatf("v%0d length", v),   32'(o_length),   32'(vecs[v].elen));
    check($sformatf("v%0d overflow", v), 32'(o_overflow), 32'(vecs[v].eovf));
    check($sformatf("v%0d err", v),      32'(o_err),      32'(vecs[v].eerr));
  endtask

  task automatic run_vec(input int v);
    start_pass(vecs[v].h, vecs[v].w, vecs[v].s);
    check($sformatf("v%0d ready after start", v), 32'(o_ready), 32'd1);
    for (int i = 0; i < vecs[v].n; i++)
      send(vecs[v].row[i], vecs[v].col[i], vecs[v].kidx[i], i == vecs[v].n - 1);
    // Cycle after the last accept: DONE with final results.
    check($sformatf("v%0d finish", v), 32'(o_finish), 32'd1);
    check($sformatf("v%0d state done", v), 32'(o_state), 32'd2);
    check($sformatf("v%0d ready in done", v), 32'(o_ready), 32'd0);
    check_results(v);
    @(posedge clk); #1;
    check($sformatf("v%0d finish drop", v), 32'(o_finish), 32'd0);
    check($sformatf("v%0d state idle", v), 32'(o_state), 32'd0);
    check($sformatf("v%0d length held", v), 32'(o_length), 32'(vecs[v].elen));
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < K; g++) begin
      check($sformatf("%s r[%0d]", tag, g),   32'(o_r[g]),   32'd0);
      check($sformatf("%s k[%0d]", tag, g),   32'(o_k[g]),   32'd0);
      check($sformatf("%s ptr[%0d]", tag, g), 32'(o_ptr[g]), 32'd0);
    end
    check({tag, " groups"},   32'(o_groups),   32'd0);
    check({tag, " length"},   32'(o_length),   32'd0);
    check({tag, " overflow"}, 32'(o_overflow), 32'd0);
    check({tag, " err"},      32'(o_err),      32'd0);
    check({tag, " ready"},    32'(o_ready),    32'd0);
    check({tag, " finish"},   32'(o_finish),   32'd0);
    check({tag, " state"},    32'(o_state),    32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // v0: basic example, three groups, unused slot points at length
    set_hdr(0, 4, 7'd20, 7'd15, 3'd2, 3'd3, 11'd4, 1'b0, 1'b0);
    set_ent(0, 0, 7'd19, 7'd13, 7'd3);
    set_ent(0, 1, 7'd19, 7'd13, 7'd3);
    set_ent(0, 2, 7'd18, 7'd13, 7'd7);
    set_ent(0, 3, 7'd17, 7'd13, 7'd7);
    set_grp(0, 0, 3'd1, 5'd3, 11'd0);
    set_grp(0, 1, 3'd2, 5'd7, 11'd2);
    set_grp(0, 2, 3'd3, 5'd7, 11'd3);
    set_grp(0, 3, 3'd0, 5'd0, 11'd4);
    // v1: six distinct k -> group overflow
    set_hdr(1, 6, 7'd10, 7'd15, 3'd2, 3'd4, 11'd6, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) set_ent(1, i, 7'd9, 7'd13, 7'(i));
    for (int g = 0; g < 4; g++) set_grp(1, g, 3'd1, 5'(g), 11'(g));
    // v2: d = -1 -> err, r = 7
    set_hdr(2, 1, 7'd20, 7'd15, 3'd2, 3'd1, 11'd1, 1'b0, 1'b1);
    set_ent(2, 0, 7'd21, 7'd13, 7'd5);
    set_grp(2, 0, 3'd7, 5'd5, 11'd0);
    for (int g = 1; g < 4; g++) set_grp(2, g, 3'd0, 5'd0, 11'd1);
    // v3: column mismatch (only flagged when the column check is built in)
    set_hdr(3, 1, 7'd20, 7'd15, 3'd2, 3'd1, 11'd1, 1'b0, COL_ERR_EXP);
    set_ent(3, 0, 7'd20, 7'd12, 7'd0);
    set_grp(3, 0, 3'd0, 5'd0, 11'd0);
    for (int g = 1; g < 4; g++) set_grp(3, g, 3'd0, 5'd0, 11'd1);
    // v4: d = 10 > 7 -> err, r = 2; kidx upper bits ignored (0x61, 0x21 -> k=1)
    set_hdr(4, 2, 7'd20, 7'd15, 3'd2, 3'd1, 11'd2, 1'b0, 1'b1);
    set_ent(4, 0, 7'd10, 7'd13, 7'h61);
    set_ent(4, 1, 7'd10, 7'd13, 7'h21);
    set_grp(4, 0, 3'd2, 5'd1, 11'd0);
    for (int g = 1; g < 4; g++) set_grp(4, g, 3'd0, 5'd0, 11'd2);
    // v5: range edges d = 7 and d = 0, no error
    set_hdr(5, 2, 7'd7, 7'd0, 3'd0, 3'd2, 11'd2, 1'b0, 1'b0);
    set_ent(5, 0, 7'd0, 7'd0, 7'd2);
    set_ent(5, 1, 7'd7, 7'd0, 7'd2);
    set_grp(5, 0, 3'd7, 5'd2, 11'd0);
    set_grp(5, 1, 3'd0, 5'd2, 11'd1);
    set_grp(5, 2, 3'd0, 5'd0, 11'd2);
    set_grp(5, 3, 3'd0, 5'd0, 11'd2);
    // v6: returning to an earlier (r,k) still opens a new group
    set_hdr(6, 3, 7'd0, 7'd0, 3'd0, 3'd3, 11'd3, 1'b0, 1'b0);
    set_ent(6, 0, 7'd0, 7'd0, 7'd31);
    set_ent(6, 1, 7'd0, 7'd0, 7'd4);
    set_ent(6, 2, 7'd0, 7'd0, 7'd31);
    set_grp(6, 0, 3'd0, 5'd31, 11'd0);
    set_grp(6, 1, 3'd0, 5'd4, 11'd1);
    set_grp(6, 2, 3'd0, 5'd31, 11'd2);
    set_grp(6, 3, 3'd0, 5'd0, 11'd3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) run_vec(v);

    // Reset mid-pass: outputs clear without a clock edge
    start_pass(7'd20, 7'd15, 3'd2);
    send(7'd19, 7'd13, 7'd3, 1'b0);
    send(7'd18, 7'd13, 7'd7, 1'b0);
    check("midpass length", 32'(o_length), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(0);

    // i_valid in IDLE is ignored; results of v0 must hold
    i_valid = 1'b1; i_row = 7'd0; i_col = 7'd0; i_kidx = 7'd9; i_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_valid = 1'b0; i_last = 1'b0;
    check("idle valid length", 32'(o_length), 32'd4);
    check("idle valid groups", 32'(o_groups), 32'd3);
    check("idle valid state",  32'(o_state),  32'd0);
    check("idle valid finish", 32'(o_finish), 32'd0);

    // i_start during RECV is ignored
    start_pass(7'd20, 7'd15, 3'd2);
    send(7'd19, 7'd13, 7'd3, 1'b0);
    i_start = 1'b1; i_h = 7'd50; i_w = 7'd1; i_s = 3'd5;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("recv start state",  32'(o_state),  32'd1);
    check("recv start length", 32'(o_length), 32'd1);
    check("recv start ready",  32'(o_ready),  32'd1);
    send(7'd19, 7'd13, 7'd3, 1'b0);
    send(7'd18, 7'd13, 7'd7, 1'b0);
    send(7'd17, 7'd13, 7'd7, 1'b1);
    check("recv start finish", 32'(o_finish), 32'd1);
    check_results(0);
    @(posedge clk); #1;

    // Length wrap: 2048 entries of one group -> length 0, overflow set
    start_pass(7'd0, 7'd0, 3'd0);
    for (int i = 0; i < 2048; i++) send(7'd0, 7'd0, 7'd0, i == 2047);
    check("wrap finish",   32'(o_finish),   32'd1);
    check("wrap length",   32'(o_length),   32'd0);
    check("wrap overflow", 32'(o_overflow), 32'd1);
    check("wrap groups",   32'(o_groups),   32'd1);
    check("wrap err",      32'(o_err),      32'd0);
    for (int g = 0; g < K; g++)
      check($sformatf("wrap ptr[%0d]", g), 32'(o_ptr[g]), 32'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_addr_encoder.md
# rf_addr_encoder

Serial encoder that reads register-file entries (row coordinate, column coordinate, kernel index) from the RF stream and rebuilds the compressed per-group description used to generate them: kernel row `r`, kernel index `k`, group start pointer `ptr` and total length. It is the inverse of the address-to-RF expander. It sits between the RF buffer and the tracking-window controller, so a window can be re-encoded after the RF is edited or checked.

## Interface
Parameters:
- `K`, 4: maximum number of groups.
- `PTR_W`, 11: pointer/length width.

Ports:
- `i_clk`  input  1  clock, rising edge.
- `i_rst`  input  1  asynchronous reset, active-high.
- `i_start`  input  1  begin an encode pass; sampled only in IDLE.
- `i_h`  input  7  window row base; latched on `i_start`.
- `i_w`  input  7  window column base; latched on `i_start`.
- `i_s`  input  3  column offset; latched on `i_start`.
- `i_valid`  input  1  RF entry valid.
- `i_row`  input  7  entry field 0 (`h - r`).
- `i_col`  input  7  entry field 1 (`w - s`).
- `i_kidx`  input  7  entry field 2 (`k`, lower 5 bits used).
- `i_last`  input  1  qualifies the final entry of the pass.
- `o_ready`  output  1  entry accepted when `i_valid & o_ready`.
- `o_r[0:K-1]`  output  3 each  per-group kernel row.
- `o_k[0:K-1]`  output  5 each  per-group kernel index.
- `o_ptr[0:K-1]`  output  PTR_W each  per-group start index.
- `o_groups`  output  3  number of groups recorded (0..K).
- `o_length`  output  PTR_W  entries accepted.
- `o_overflow`  output  1  more than K groups, or length wrapped.
- `o_err`  output  1  range or column error seen.
- `o_finish`  output  1  one-cycle pulse at pass end.

## Operation
- States: IDLE, RECV, DONE.
- IDLE:
  - `o_ready=0`.
  - On `i_start`: latch `i_h`/`i_w`/`i_s`; clear all result outputs (`o_ptr[g]=0`, `o_r`/`o_k=0`, counters, flags); go to RECV.
- RECV:
  - `o_ready=1`.
  - For each accepted entry, `d = i_h - i_row` (8-bit signed). If `d<0` or `d>7`, set `o_err`; the recorded `r` is `d[2:0]`. `k = i_kidx[4:0]`.
  - A new group opens on the first entry, or when `(r,k)` differs from the current group.
  - Opening group g (`g < K`): `o_r[g]=r`, `o_k[g]=k`, `o_ptr[g]=o_length` (index of this entry), then `o_groups+1`.
  - Opening a group when `o_groups==K`: set `o_overflow`; group arrays are unchanged.
  - `o_length` increments every accept. Wrap from 2^PTR_W-1 to 0 sets `o_overflow`.
  - Accept with `i_last=1`: go to DONE.
- DONE: `o_finish=1` for one cycle, then IDLE.
  - Entries for group slots ≥ `o_groups` are filled as `o_ptr=o_length`, `r=k=0`.
  - Results hold until the next `i_start`.
- `i_start` outside IDLE is ignored. `i_valid` outside RECV is ignored.
- `o_err` and `o_overflow` are sticky within a pass and cleared only by `i_start` or reset.

## Timing
- Reset (async, `i_rst=1`): state IDLE; all outputs 0, including `o_ready`, `o_finish`, and all array elements. Reset mid-pass discards the pass.
- `i_start` at edge n: `o_ready=1` from cycle n+1.
- Entry accepted at edge n: `o_length`, `o_groups` and group arrays reflect it after edge n (visible in cycle n+1).
- Last entry accepted at edge n: cycle n+1 is DONE with `o_finish=1` and final results valid; cycle n+2 is IDLE.
- Minimum pass with one entry: `i_start` → 3 cycles to `o_finish`.
- Throughput: one entry per cycle. No backpressure inside RECV.

## Configuration
- `RF_COL_CHECK_EN` defined: each accepted entry is also checked against `i_col == i_w - i_s` (7-bit wrap). A mismatch sets `o_err`.
- Undefined: `i_col` is ignored. `o_err` reflects only the row-range check.

## Test plan
- h=20, w=15, s=2; entries (19,13,3), (19,13,3), (18,13,7), (17,13,7, last) → r={1,2,3,0}, k={3,7,7,0}, ptr={0,2,3,4}, groups=3, length=4, flags 0, `o_finish` 1 cycle after last accept.
- Six entries each with distinct k (h=10, row=9) → groups=4, ptr={0,1,2,3}, `o_overflow=1`, length=6.
- row=21 with h=20 (d=-1) → `o_err=1`; the group is still recorded with r=7.
- With `RF_COL_CHECK_EN`, w=15, s=2, entry col=12 → `o_err=1`. Without the macro → `o_err=0`.
- Assert `i_rst` after 2 of 4 entries → all outputs 0 asynchronously. A new `i_start` pass then yields results for the new entries only.
- `i_start` pulsed during RECV and `i_valid` during IDLE → no effect on state or results.
